// File: rtl/serial_logic_unit_if.sv
// Request/response bundle for the serial logic unit.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and response channels.
interface serial_logic_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;

    // Producer/consumer side of the unit
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_err
    );

    // The serial logic unit itself
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_err
    );
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial logic-op engine: applies AND/OR/XOR/NAND/NOR/NOT_A SLICE bits per cycle, LSB first.
// Latency: WIDTH/SLICE cycles from accept to out_valid for legal ops, 1 cycle for illegal ops.
// Backpressure: one op in flight; in_ready low in RUN/DONE, result held in DONE until out_ready.
module serial_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_logic_unit_if.slave   bus,
    output logic                 busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_NOT_A = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] sl_res;
    logic             op_legal;

    // Gate slice: combines the low SLICE bits of the operand shift registers
    always_comb begin
        a_sl = a_q[SLICE-1:0];
        b_sl = b_q[SLICE-1:0];
        case (op_q)
            OP_AND:   sl_res = a_sl & b_sl;
            OP_OR:    sl_res = a_sl | b_sl;
            OP_XOR:   sl_res = a_sl ^ b_sl;
            OP_NAND:  sl_res = ~(a_sl & b_sl);
            OP_NOR:   sl_res = ~(a_sl | b_sl);
            OP_NOT_A: sl_res = ~a_sl;
            default:  sl_res = '0;
        endcase
    end

    // Ops 6 and 7 are undefined and short-circuit to an error response
    assign op_legal = (bus.in_op <= OP_NOT_A);

    // Next-state logic for the FSM, datapath and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone is the accept
                if (bus.in_valid) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    op_d  = bus.in_op;
                    res_d = '0;
                    cnt_d = CNT_W'(NSLICE - 1);
                    if (op_legal) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                // New slice enters at the top so bit i lands at position i after NSLICE shifts
                res_d                  = res_q >> SLICE;
                res_d[WIDTH-1 -: SLICE] = sl_res;
                a_d                    = a_q >> SLICE;
                b_d                    = b_q >> SLICE;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // The illegal-op path enters DONE with out_valid low; it rises one cycle later
                if (out_valid_q && bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                err_d       = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_err    = err_q;
    assign busy           = busy_q;

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
Multi-cycle controller that sequences a narrow bitwise logic slice (AND/OR/XOR/NAND/NOR/NOT-A gate set) across a full operand word, SLICE bits per cycle, LSB first. It sits beside the RV32I ALU as an area-reduced logic-op engine. It accepts one operation through a valid/ready request port and returns the WIDTH-bit result through a valid/ready response port. An FSM controls operand shifting, the slice counter and the handshakes.

Parameters:
WIDTH, 32, operand/result width in bits
SLICE, 1, bits processed per cycle; must divide WIDTH (legal values 1, 2, 4, 8, 16, 32)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_op  in  3  0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=NOT_A 6,7=illegal
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B (ignored for NOT_A)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  computed word
out_err  out  1  request carried an illegal op
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_err=0, busy=0, counter=0, operand registers=0.
- FSM has three states: IDLE, RUN and DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge T:
  - Latch in_a, in_b and in_op.
  - Clear the result register and set counter=WIDTH/SLICE-1.
  - Legal op: go to RUN. Illegal op: go straight to DONE with out_result=0 and out_err=1.
- RUN: in_ready=0.
  - Each cycle, apply op to the low SLICE bits of the A/B shift registers.
  - Shift the result right by SLICE and insert the new slice at the top.
  - Shift A and B right by SLICE.
  - When counter=0, go to DONE on that edge; otherwise decrement the counter.
- Latency, legal op: out_valid rises after edge T+WIDTH/SLICE (32 cycles at defaults; 1 cycle at SLICE=WIDTH).
- Latency, illegal op: out_valid rises after edge T+1.
- DONE: out_valid=1. out_result and out_err are held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE, deassert out_valid, clear out_err. out_result keeps its last value.
- No pass-through: in_ready is 0 throughout RUN and DONE. A new request is accepted at the earliest one cycle after the response handshake.
- in_a, in_b and in_op may change freely after acceptance; only the latched copies are used.
- in_valid asserted while busy: ignored and not queued. The producer must hold in_valid until in_ready.
- Bit ordering: result bit i is exactly op(a[i], b[i]). NAND, NOR and NOT_A invert within WIDTH bits only.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The pending result is discarded and no out_valid pulse is issued.
- out_ready high while out_valid=0: no effect.
- Every register resets asynchronously on rst_n; deassertion is assumed synchronised externally.

Test Plan:
- Reset release, then op=0 (AND), a=0xF0F01234, b=0x0FF0FFFF -> out_valid rises exactly 32 cycles after the accept edge; out_result=0x00F01234, out_err=0; in_ready=0 throughout the operation.
- Back-to-back XOR and OR, same operands, out_ready tied high -> results 0xFF00EDCB then 0xFFF0FFFF.
  - Second accept occurs one cycle after the first response handshake.
  - No request is lost and none is duplicated.
- op=5 (NOT_A), a=0xF0F01234, b=0xFFFFFFFF -> 0x0F0FEDCB.
  - Then op=3 (NAND) with a=b=0xFFFFFFFF -> 0x00000000.
  - Then op=4 (NOR) with a=b=0 -> 0xFFFFFFFF.
- op=6 with arbitrary operands -> out_valid one cycle after accept, out_result=0, out_err=1.
  - out_err clears after the handshake.
  - A following legal AND completes normally.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_result and out_valid remain stable; in_ready stays 0; in_valid pulses during the stall are ignored.
- rst_n pulsed low at cycle 15 of RUN -> outputs immediately return to reset values with no out_valid pulse.
  - The next request completes correctly.
  - Repeat the AND case with SLICE=8: latency is 4 cycles.
